// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter / fetch sequencer.
// The fetch state enum always lists HALT; it is only reachable when PC_FETCH_HALT_EN is defined.
package pc_fetch_pkg;

    localparam int PC_W = 16;
    localparam int OP_W = 8;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        OPHI,
        OPLO,
        EXEC,
        HALT
    } state_t;

endpackage

// File: rtl/pc_reg.sv
// 16-bit program counter register with load-over-increment priority.
// Also exposes the incremented value combinationally; it wraps modulo 2^16.
module pc_reg
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1
);

    assign pc_plus1 = pc + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc_plus1;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter and fetch sequencer feeding the jump unit and execute logic.
// Optional halt-on-opcode support is enabled by defining PC_FETCH_HALT_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [OP_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_re,
    input  logic            mem_ready,
    input  logic [OP_W-1:0] mem_rdata,
    output logic [OP_W-1:0] cins,
    input  logic            is_jmp,
    output logic [OP_W-1:0] databus_out,
    output logic            highbits_we,
    output logic            jmp_oe,
    output logic [PC_W-1:0] pc_to_jmp,
    input  logic            pcoe,
    input  logic [PC_W-1:0] pcout,
    output logic            exec_stb,
    output logic            busy
);

`ifdef PC_FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    state_t          state;
    state_t          next_state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus1;
    logic            pc_load;
    logic            pc_inc;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_val (pcout),
        .inc      (pc_inc),
        .pc       (pc),
        .pc_plus1 (pc_plus1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            cins  <= '0;
        end else begin
            state <= next_state;
            if (state == FETCH && mem_ready) begin
                cins <= mem_rdata;
            end
        end
    end

    // Reset masks every strobe so a late mem_ready cannot leak a latch enable.
    always_comb begin
        next_state  = state;
        mem_re      = 1'b0;
        highbits_we = 1'b0;
        jmp_oe      = 1'b0;
        exec_stb    = 1'b0;
        databus_out = '0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        pc_inc     = 1'b1;
                        next_state = DECODE;
                    end
                end
                DECODE: begin
                    if (HALT_EN && cins == HALT_OPCODE) begin
                        next_state = HALT;
                    end else if (is_jmp) begin
                        next_state = OPHI;
                    end else begin
                        next_state = EXEC;
                    end
                end
                EXEC: begin
                    exec_stb   = 1'b1;
                    next_state = FETCH;
                end
                OPHI: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        databus_out = mem_rdata;
                        highbits_we = 1'b1;
                        pc_inc      = 1'b1;
                        next_state  = OPLO;
                    end
                end
                OPLO: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        databus_out = mem_rdata;
                        jmp_oe      = 1'b1;
                        pc_load     = pcoe;
                        pc_inc      = !pcoe;
                        next_state  = FETCH;
                    end
                end
                HALT: begin
                    next_state = HALT;
                end
                default: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

    assign mem_addr  = pc;
    assign busy      = (state != FETCH);
    assign pc_to_jmp = jmp_oe ? pc_plus1 : pc;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed vector table, reset/halt sequences and random instructions.
// Expected results come from a per-instruction model of the fetch rules, not from the RTL.
module tb_pc_fetch;

    localparam logic [15:0] RESET_PC = 16'h0100;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  opcode;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          waits;
        logic        take;
        logic [15:0] target;
        int          exp_cycles;
        logic [15:0] exp_next;
        logic [15:0] exp_ptj;
        int          exp_exec;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic [7:0]  cins;
    logic        is_jmp;
    logic [7:0]  databus_out;
    logic        highbits_we;
    logic        jmp_oe;
    logic [15:0] pc_to_jmp;
    logic        pcoe;
    logic [15:0] pcout;
    logic        exec_stb;
    logic        busy;

    logic [7:0]  mem [65536];
    int          wait_cnt;
    int          total;
    int          bad;
    logic [15:0] model_pc;

    pc_fetch #(
        .RESET_PC    (RESET_PC),
        .HALT_OPCODE (8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .cins        (cins),
        .is_jmp      (is_jmp),
        .databus_out (databus_out),
        .highbits_we (highbits_we),
        .jmp_oe      (jmp_oe),
        .pc_to_jmp   (pc_to_jmp),
        .pcoe        (pcoe),
        .pcout       (pcout),
        .exec_stb    (exec_stb),
        .busy        (busy)
    );

    // Opcodes with the two top bits set stand in for the jump unit's decode.
    assign is_jmp = (cins[7:6] == 2'b11);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One cycle: memory answers at the negedge after the requested number of wait cycles.
    task automatic stepCycle(input int waits);
        @(negedge clk);
        if (mem_re && wait_cnt >= waits) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
            wait_cnt  = 0;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_re) wait_cnt++;
        end
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        wait_cnt  = 0;
        #1;
        checkOutput("reset_mem_re", {31'd0, mem_re}, 32'd0);
        checkOutput("reset_strobes", {29'd0, exec_stb, highbits_we, jmp_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_pc = RESET_PC;
    endtask

    function automatic vec_t modelInstr(input vec_t v);
        vec_t r;
        r = v;
        if (v.opcode[7:6] == 2'b11) begin
            r.exp_cycles = 4 + 3 * v.waits;
            r.exp_ptj    = v.pc + 16'd3;
            r.exp_next   = v.take ? v.target : v.pc + 16'd3;
            r.exp_exec   = 0;
        end else begin
            r.exp_cycles = 3 + v.waits;
            r.exp_ptj    = 16'h0000;
            r.exp_next   = v.pc + 16'd1;
            r.exp_exec   = 1;
        end
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        logic [15:0] exp_addr [3];
        int          cycles;
        int          exec_n;
        int          hb_n;
        int          oe_n;
        int          r;
        logic        done;
        logic        rule_ok;
        logic        addr_ok;
        logic [7:0]  hb_data;
        logic [7:0]  oe_data;
        logic [15:0] ptj;
        logic [7:0]  cins_seen;

        exp_addr[0] = v.pc;
        exp_addr[1] = v.pc + 16'd1;
        exp_addr[2] = v.pc + 16'd2;
        mem[exp_addr[0]] = v.opcode;
        mem[exp_addr[1]] = v.b1;
        mem[exp_addr[2]] = v.b2;
        pcoe      = v.take;
        pcout     = v.target;
        cycles    = 0;
        exec_n    = 0;
        hb_n      = 0;
        oe_n      = 0;
        r         = 0;
        done      = 1'b0;
        rule_ok   = 1'b1;
        addr_ok   = 1'b1;
        hb_data   = 8'h00;
        oe_data   = 8'h00;
        ptj       = 16'h0000;
        cins_seen = 8'h00;
        wait_cnt  = 0;

        while (!done && cycles < 80) begin
            stepCycle(v.waits);
            cycles++;
            if (cycles == 1) begin
                checkOutput("start_addr", {16'd0, mem_addr}, {16'd0, v.pc});
                checkOutput("start_fetch", {30'd0, busy, mem_re}, 32'd1);
            end
            if (mem_re) begin
                if (r > 2 || mem_addr != exp_addr[r > 2 ? 2 : r]) addr_ok = 1'b0;
                if (mem_ready) r++;
            end
            if (highbits_we && jmp_oe) rule_ok = 1'b0;
            if ((highbits_we || jmp_oe) && !mem_ready) rule_ok = 1'b0;
            if (!(highbits_we || jmp_oe) && databus_out != 8'h00) rule_ok = 1'b0;
            if (highbits_we) begin
                hb_n++;
                hb_data = databus_out;
            end
            if (jmp_oe) begin
                oe_n++;
                oe_data   = databus_out;
                ptj       = pc_to_jmp;
                cins_seen = cins;
                done      = 1'b1;
            end
            if (exec_stb) begin
                exec_n++;
                cins_seen = cins;
                done      = 1'b1;
            end
        end

        checkOutput("instr_done", {31'd0, done}, 32'd1);
        if (!done) begin
            doReset();
            return;
        end

        @(posedge clk);
        #1;
        checkOutput("next_addr", {16'd0, mem_addr}, {16'd0, v.exp_next});
        checkOutput("back_to_fetch", {30'd0, busy, exec_stb}, 32'd0);
        checkOutput("cycles", cycles, v.exp_cycles);
        checkOutput("exec_count", exec_n, v.exp_exec);
        checkOutput("cins", {24'd0, cins_seen}, {24'd0, v.opcode});
        checkOutput("req_addr_stable", {31'd0, addr_ok}, 32'd1);
        checkOutput("strobe_rules", {31'd0, rule_ok}, 32'd1);
        if (v.exp_exec == 0) begin
            checkOutput("hb_count", hb_n, 1);
            checkOutput("hb_data", {24'd0, hb_data}, {24'd0, v.b1});
            checkOutput("oe_data", {24'd0, oe_data}, {24'd0, v.b2});
            checkOutput("pc_to_jmp", {16'd0, ptj}, {16'd0, v.exp_ptj});
        end else begin
            checkOutput("jmp_strobes", hb_n + oe_n, 0);
        end
        model_pc = v.exp_next;
    endtask

    initial begin
        vec_t        table_v [9];
        vec_t        v;
        logic        halt_ok;
        logic [15:0] halt_addr;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        pcoe      = 1'b0;
        pcout     = 16'h0000;
        wait_cnt  = 0;
        model_pc  = RESET_PC;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        //               pc      op     b1     b2     w  take target  cyc next     ptj      exec
        table_v[0] = '{16'h0100, 8'h12, 8'h00, 8'h00, 0, 1'b0, 16'h0000, 3, 16'h0101, 16'h0000, 1};
        table_v[1] = '{16'h0101, 8'hC3, 8'h00, 8'h00, 0, 1'b1, 16'h0000, 4, 16'h0000, 16'h0104, 0};
        table_v[2] = '{16'h0000, 8'hC3, 8'h12, 8'h34, 0, 1'b1, 16'h1234, 4, 16'h1234, 16'h0003, 0};
        table_v[3] = '{16'h1234, 8'hC3, 8'h00, 8'h00, 0, 1'b1, 16'h0000, 4, 16'h0000, 16'h1237, 0};
        table_v[4] = '{16'h0000, 8'hC3, 8'h12, 8'h34, 0, 1'b0, 16'h1234, 4, 16'h0003, 16'h0003, 0};
        table_v[5] = '{16'h0003, 8'hC3, 8'h56, 8'h78, 2, 1'b0, 16'h5678, 10, 16'h0006, 16'h0006, 0};
        table_v[6] = '{16'h0006, 8'hC3, 8'hFF, 8'hFF, 1, 1'b1, 16'hFFFF, 7, 16'hFFFF, 16'h0009, 0};
        table_v[7] = '{16'hFFFF, 8'h12, 8'h00, 8'h00, 0, 1'b0, 16'h0000, 3, 16'h0000, 16'h0000, 1};
        table_v[8] = '{16'h0000, 8'h7E, 8'h00, 8'h00, 3, 1'b0, 16'h0000, 6, 16'h0001, 16'h0000, 1};

        doReset();
        checkOutput("post_reset_addr", {16'd0, mem_addr}, {16'd0, RESET_PC});
        checkOutput("post_reset_re", {31'd0, mem_re}, 32'd1);
        checkOutput("post_reset_cins", {24'd0, cins}, 32'd0);
        checkOutput("post_reset_strobes", {28'd0, exec_stb, highbits_we, jmp_oe, busy}, 32'd0);
        checkOutput("post_reset_databus", {24'd0, databus_out}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(table_v[i]);
        end

        // Reset landing on an operand-accept cycle must swallow the high-byte strobe.
        mem[model_pc]         = 8'hC3;
        mem[model_pc + 16'd1] = 8'h11;
        stepCycle(0);
        stepCycle(0);
        checkOutput("decode_no_req", {30'd0, busy, mem_re}, 32'd2);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 8'h5A;
        #1;
        checkOutput("rst_ophi_hb", {31'd0, highbits_we}, 32'd0);
        checkOutput("rst_ophi_bus", {23'd0, mem_re, databus_out}, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ready = 1'b0;
        wait_cnt  = 0;
        #1;
        checkOutput("rst_ophi_pc", {16'd0, mem_addr}, {16'd0, RESET_PC});
        checkOutput("rst_ophi_cins", {24'd0, cins}, 32'd0);
        checkOutput("rst_ophi_busy", {31'd0, busy}, 32'd0);
        model_pc = RESET_PC;

`ifdef PC_FETCH_HALT_EN
        mem[model_pc] = 8'hFF;
        halt_addr     = model_pc + 16'd1;
        stepCycle(0);
        stepCycle(0);
        halt_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stepCycle(0);
            if (mem_re || !busy || exec_stb || highbits_we || jmp_oe || mem_addr != halt_addr) halt_ok = 1'b0;
        end
        checkOutput("halt_hold", {31'd0, halt_ok}, 32'd1);
        doReset();
        checkOutput("halt_refetch_addr", {16'd0, mem_addr}, {16'd0, RESET_PC});
        checkOutput("halt_refetch_re", {31'd0, mem_re}, 32'd1);
`else
        halt_ok   = 1'b0;
        halt_addr = 16'h0000;
        v.pc     = model_pc;
        v.opcode = 8'hFF;
        v.b1     = 8'hAA;
        v.b2     = 8'hBB;
        v.waits  = 0;
        v.take   = 1'b0;
        v.target = 16'h4321;
        applyStimulus(modelInstr(v));
`endif

        for (int i = 0; i < 40; i++) begin
            v.pc     = model_pc;
            v.opcode = 8'($urandom);
`ifdef PC_FETCH_HALT_EN
            if (v.opcode == 8'hFF) v.opcode = 8'hFE;
`endif
            v.b1     = 8'($urandom);
            v.b2     = 8'($urandom);
            v.waits  = $urandom_range(0, 3);
            v.take   = 1'($urandom);
            v.target = 16'($urandom);
            applyStimulus(modelInstr(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program-counter and fetch sequencer for the 8-bit CPU: the other end of the jump unit's interface.
- Owns the 16-bit PC and fetches opcode bytes over a byte-wide memory read handshake.
- For jump opcodes, fetches the two address operand bytes, strobes the jump unit's `highbits_we` and `oe`, then loads the PC from `pcout` when `pcoe` is asserted.
- Non-jump opcodes are handed to the execute logic through a one-cycle strobe.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- HALT_OPCODE, 8'hFF, opcode that halts fetch (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_addr  output  16  read address; equals the PC register.
- mem_re  output  1  read request; held high until `mem_ready`.
- mem_ready  input  1  read data valid this cycle; completes the request.
- mem_rdata  input  8  read data byte.
- cins  output  8  latched instruction register; drives the jump unit's opcode input.
- is_jmp  input  1  combinational decode of `cins`: 1 = jump opcode with a 2-byte operand.
- databus_out  output  8  equals `mem_rdata` during operand-accept cycles, else 0.
- highbits_we  output  1  jump unit high-byte latch enable.
- jmp_oe  output  1  jump unit output enable.
- pc_to_jmp  output  16  PC value supplied to the jump unit (its `pcin`).
- pcoe  input  1  jump taken.
- pcout  input  16  jump target.
- exec_stb  output  1  one-cycle pulse: `cins` holds a non-jump instruction ready to execute.
- busy  output  1  high in every state except FETCH.

Behaviour:
- Reset:
  - Takes effect synchronously and overrides everything, including a mid-fetch `mem_ready`.
  - Sets PC=RESET_PC, `cins`=0, state=FETCH.
  - All strobes go to 0, `databus_out`=0, `mem_re`=0 for the reset cycle.
- States are FETCH, DECODE, OPHI, OPLO, EXEC (plus HALT with the optional feature).
- FETCH:
  - `mem_re`=1.
  - On `mem_ready`: `cins` <= `mem_rdata`, PC <= PC+1, go to DECODE.
  - Without `mem_ready`: hold, for any number of wait cycles.
- DECODE (one cycle, no memory request):
  - `is_jmp`=1 -> OPHI.
  - Otherwise -> EXEC.
- EXEC: `exec_stb`=1 for exactly one cycle, then FETCH.
- OPHI:
  - `mem_re`=1.
  - On `mem_ready`: `databus_out`=`mem_rdata`, `highbits_we`=1 in that same cycle, PC <= PC+1, go to OPLO.
- OPLO:
  - `mem_re`=1.
  - On `mem_ready`: `databus_out`=`mem_rdata`, `jmp_oe`=1, `pc_to_jmp`=PC+1 (address following the operand), combinationally in that cycle.
  - If `pcoe`: PC <= `pcout`; else PC <= PC+1.
  - Next state is FETCH.
- `pc_to_jmp` equals the PC register in all other cycles.
- Arithmetic: PC is 16-bit and wraps modulo 2^16. FFFF+1 = 0000, in every increment.
- `highbits_we` and `jmp_oe` are never high in the same cycle, and are never high without `mem_ready`.
- Latency:
  - Non-jump instruction: 3 cycles with zero-wait memory (FETCH, DECODE, EXEC).
  - Jump: 4 cycles (FETCH, DECODE, OPHI, OPLO).
  - Each memory wait cycle adds one cycle.
- `mem_addr` changes only in the cycle after a `mem_ready`, so it is stable for the whole of a request.

Optional Feature:
- Macro: PC_FETCH_HALT_EN.
- Defined:
  - In DECODE, `cins`==HALT_OPCODE -> HALT (checked before `is_jmp`).
  - HALT: `mem_re`=0, `busy`=1, no strobes, PC frozen.
  - Only `rst` leaves HALT.
- Undefined: HALT state absent; HALT_OPCODE is treated like any other opcode.

Decomposition:
- Package pc_fetch_pkg:
  - state enum typedef (FETCH, DECODE, OPHI, OPLO, EXEC, HALT).
  - PC width constant, 16.
  - Opcode width constant, 8.
  - Default reset-PC constant.
- Sub-module pc_reg:
  - 16-bit register, synchronous reset to RESET_PC.
  - Priority: load (`pcout`) over increment over hold.
  - Exposes the PC and PC+1 combinationally.
- FSM and output decode stay in pc_fetch.

Test Plan:
- Reset with RESET_PC=16'h0100: `mem_addr`=0100 and `mem_re`=1 on the first post-reset cycle; `cins`=00; all strobes 0.
- Non-jump opcode: memory returns 8'h12 at 0100 with zero wait, `is_jmp`=0 -> `exec_stb` pulses once on cycle 3; next fetch at 0101.
- Taken absolute jump:
  - Opcode at 0000, `is_jmp`=1; operands 8'h12 at 0001 and 8'h34 at 0002.
  - `highbits_we` with `databus_out`=12, then `jmp_oe` with `databus_out`=34 and `pc_to_jmp`=0003.
  - `pcoe`=1, `pcout`=1234 -> next `mem_addr`=1234.
- Not-taken jump: same stimulus with `pcoe`=0 -> next fetch at 0003. Also: 2 wait cycles on each read extend the sequence by exactly 6 cycles with `mem_addr` stable throughout.
- Wrap and reset:
  - Fetch of a non-jump opcode at FFFF -> next fetch at 0000.
  - `rst` asserted in OPHI during a `mem_ready` cycle -> no `highbits_we`; PC=RESET_PC next cycle.
- PC_FETCH_HALT_EN defined:
  - Opcode FF -> HALT; `mem_re` stays 0 for 20 cycles; `busy`=1.
  - `rst` -> refetch from RESET_PC.
  - With the macro undefined, FF follows the normal `is_jmp` path.
